// File: rtl/decoder_3_8_seq.sv
// decoder_3_8_seq
//   Sequenced 3-to-8 one-hot decoder. Codes arrive over a valid/ready
//   handshake into a 2-entry FIFO. Each popped code drives y[code] for
//   HOLD_CYCLES clocks, followed by GAP_CYCLES clocks of all-zero output.
//
//   clk       in   1  clock, rising edge
//   rst_n     in   1  synchronous active-low reset
//   in_code   in   3  code to decode
//   in_valid  in   1  in_code valid
//   in_ready  out  1  a code can be accepted this cycle
//   en        in   1  permit popping the next buffered code
//   y         out  8  one-hot output while active, else 8'h00
//   y_valid   out  1  y is driving a code
//   busy      out  1  not idle, or buffer non-empty
module decoder_3_8_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       en,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] y_q, y_d;
  logic       y_valid_q, y_valid_d;

  logic [2:0] mem_q [2];
  logic [2:0] mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  logic       push;
  logic       pop;
  logic       can_pop;
  logic [2:0] head_code;

  always_comb begin
    in_ready  = (count_q != 2'd2) && rst_n;
    push      = in_valid && in_ready;
    head_code = mem_q[rd_ptr_q];
    can_pop   = (count_q != 2'd0) && en;
  end

  // Control: every path that starts a hold pops the head and loads the
  // hold counter; the counter counts down to 0 inclusive.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          y_d       = 8'b0000_0001 << head_code;
          y_valid_d = 1'b1;
          cnt_d     = HOLD_LOAD;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (GAP_CYCLES > 0) begin
          y_d       = '0;
          y_valid_d = 1'b0;
          cnt_d     = GAP_LOAD;
          state_d   = GAP;
        end else if (can_pop) begin
          // Back-to-back reload: y switches codes with no zero cycle.
          pop       = 1'b1;
          y_d       = 8'b0000_0001 << head_code;
          y_valid_d = 1'b1;
          cnt_d     = HOLD_LOAD;
        end else begin
          y_d       = '0;
          y_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      GAP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (can_pop) begin
          pop       = 1'b1;
          y_d       = 8'b0000_0001 << head_code;
          y_valid_d = 1'b1;
          cnt_d     = HOLD_LOAD;
          state_d   = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        y_d       = '0;
        y_valid_d = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; a push never happens when full because in_ready is low.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_code;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      mem_q     <= '{default: '0};
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_decoder_3_8_seq.sv
// tb_decoder_3_8_seq
//   Two decoders (GAP=1 and GAP=0, HOLD=4) share one stimulus stream.
//   A per-instance model (code list + remaining hold/gap cycle counts) is
//   compared against both on every falling edge; directed sections add
//   hand-computed literal expectations.
module tb_decoder_3_8_seq;

  localparam int HOLD  = 4;
  localparam int GAP_A = 1;
  localparam int GAP_B = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] in_code;
  logic       in_valid;
  logic       en;

  logic       a_in_ready, a_y_valid, a_busy;
  logic [7:0] a_y;
  logic       b_in_ready, b_y_valid, b_busy;
  logic [7:0] b_y;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  decoder_3_8_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
    .in_ready(a_in_ready), .en(en), .y(a_y), .y_valid(a_y_valid), .busy(a_busy)
  );

  decoder_3_8_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
    .in_ready(b_in_ready), .en(en), .y(b_y), .y_valid(b_y_valid), .busy(b_busy)
  );

  // ---------------- model ----------------
  int m_cnt  [2] = '{default: 0};
  int m_buf  [2][2];
  int m_cur  [2] = '{default: 0};
  int m_hold [2] = '{default: 0};
  int m_gap  [2] = '{default: 0};

  task automatic model_step(input int i, input int gap);
    bit can_pop, do_push, start;
    if (!rst_n) begin
      m_cnt[i] = 0; m_hold[i] = 0; m_gap[i] = 0;
      return;
    end
    do_push = in_valid && (m_cnt[i] < 2);
    can_pop = (m_cnt[i] > 0) && en;
    start   = 1'b0;
    if (m_hold[i] > 0) begin
      m_hold[i]--;
      if (m_hold[i] == 0) begin
        if (gap > 0) m_gap[i] = gap;
        else         start = can_pop;
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
      if (m_gap[i] == 0) start = can_pop;
    end else begin
      start = can_pop;
    end
    if (start) begin
      m_cur[i]    = m_buf[i][0];
      m_buf[i][0] = m_buf[i][1];
      m_cnt[i]--;
      m_hold[i]   = HOLD;
    end
    if (do_push) begin
      m_buf[i][m_cnt[i]] = int'(in_code);
      m_cnt[i]++;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, GAP_A);
    model_step(1, GAP_B);
  end

  function automatic logic [7:0] exp_y(input int i);
    return (m_hold[i] > 0) ? 8'(1 << m_cur[i]) : 8'h00;
  endfunction

  function automatic logic exp_busy(input int i);
    return (m_hold[i] > 0) || (m_gap[i] > 0) || (m_cnt[i] > 0);
  endfunction

  function automatic logic exp_ready(input int i);
    return (m_cnt[i] < 2) && rst_n;
  endfunction

  // ---------------- checking ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check8("model_a_y",       a_y,        exp_y(0));
      check1("model_a_y_valid", a_y_valid,  m_hold[0] > 0);
      check1("model_a_busy",    a_busy,     exp_busy(0));
      check1("model_a_ready",   a_in_ready, exp_ready(0));
      check8("model_b_y",       b_y,        exp_y(1));
      check1("model_b_y_valid", b_y_valid,  m_hold[1] > 0);
      check1("model_b_busy",    b_busy,     exp_busy(1));
      check1("model_b_ready",   b_in_ready, exp_ready(1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy;
    logic [7:0] e;

    // 1. reset
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; en = 1'b1;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    @(negedge clk);
    check8("rst_y",       a_y,        8'h00);
    check1("rst_y_valid", a_y_valid,  1'b0);
    check1("rst_busy",    a_busy,     1'b0);
    check1("rst_ready",   a_in_ready, 1'b0);
    check1("rst_ready_b", b_in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check1("rst_release_ready", a_in_ready, 1'b1);
    idle(2);

    // 2. single code 5
    in_code = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      check8("t2_y",       a_y,       (k >= 1 && k <= 4) ? 8'h20 : 8'h00);
      check1("t2_y_valid", a_y_valid, k >= 1 && k <= 4);
      check1("t2_busy",    a_busy,    k <= 5);
    end
    tick();
    idle(4);

    // 3. back-to-back 0,7 (GAP=0 instance)
    in_code = 3'd0; in_valid = 1'b1;
    tick();
    in_code = 3'd7;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      e = (k <= 4) ? 8'h01 : (k <= 8) ? 8'h80 : 8'h00;
      check8("t3_y",     b_y,        e);
      check1("t3_ready", b_in_ready, 1'b1);
    end
    tick();
    idle(8);

    // 4. full buffer with en=0, then release
    en = 1'b0;
    in_code = 3'd1; in_valid = 1'b1;
    tick();
    in_code = 3'd2;
    tick();
    in_code = 3'd3;
    @(negedge clk);
    check1("t4_full_ready_a", a_in_ready, 1'b0);
    check1("t4_full_ready_b", b_in_ready, 1'b0);
    tick();
    @(negedge clk);
    check1("t4_full_hold", a_in_ready, 1'b0);
    tick();
    en  = 1'b1;
    rdy = a_in_ready;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (in_valid && rdy) in_valid = 1'b0;
      @(negedge clk);
      e = (k <= 4) ? 8'h02 : (k == 5) ? 8'h00 : (k <= 9) ? 8'h04 :
          (k == 10) ? 8'h00 : (k <= 14) ? 8'h08 : 8'h00;
      check8("t4_y", a_y, e);
      if (k == 1) check1("t4_slot_free", a_in_ready, 1'b1);
      rdy = a_in_ready;
    end
    in_valid = 1'b0;
    tick();
    idle(6);

    // 5. en dropped mid-hold
    en = 1'b1;
    in_code = 3'd4; in_valid = 1'b1;
    tick();
    in_code = 3'd6;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (k == 2)  en = 1'b0;
      if (k == 10) en = 1'b1;
      @(negedge clk);
      e = (k <= 4) ? 8'h10 : (k <= 10) ? 8'h00 : 8'h40;
      check8("t5_y", a_y, e);
      if (k == 8) check1("t5_busy_buffered", a_busy, 1'b1);
    end
    tick();
    idle(10);

    // 6. reset while active with two codes buffered
    en = 1'b1;
    in_code = 3'd2; in_valid = 1'b1;
    tick();
    in_code = 3'd5;
    tick();
    in_code = 3'd7;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check8("t6_pre_y",    a_y,    8'h04);
    check1("t6_pre_busy", a_busy, 1'b1);
    tick();
    @(negedge clk);
    check8("t6_rst_y",       a_y,        8'h00);
    check1("t6_rst_y_valid", a_y_valid,  1'b0);
    check1("t6_rst_busy",    a_busy,     1'b0);
    check1("t6_rst_busy_b",  b_busy,     1'b0);
    check1("t6_rst_ready",   a_in_ready, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check8("t6_stale_a", a_y, 8'h00);
      check8("t6_stale_b", b_y, 8'h00);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
